// File: rtl/softmax_max_sub.sv
`default_nettype none
// ============================================================================
// Module   : softmax_max_sub
// Purpose  : Softmax front end. Buffers one vector while tracking its signed
//            maximum, then replays each element as (x - max) <= 0.
//            Optional macro SOFTMAX_SAT_EN clamps the output to -2^(DW-1).
// Revision : 1.0 - initial release
// ============================================================================
module softmax_max_sub #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH:0]   out_data,
  output logic                         out_last,
  output logic signed [DATA_WIDTH-1:0] max_val
);

  localparam int            CW       = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);
  localparam logic signed [DATA_WIDTH:0] SAT_FLOOR = {2'b11, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]                rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]                last_idx_q, last_idx_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic signed [DATA_WIDTH:0]   out_data_q, out_data_d;
  logic signed [DATA_WIDTH-1:0] mem_q [VEC_LEN];

  logic                         w_in_fire;
  logic                         w_out_fire;
  logic                         w_vec_end;
  logic signed [DATA_WIDTH-1:0] w_max_nxt;
  logic signed [DATA_WIDTH-1:0] w_first;
  logic [CW-1:0]                w_rd_nxt;

  function automatic logic signed [DATA_WIDTH:0] sub_max(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] m
  );
    logic signed [DATA_WIDTH:0] d;
    d = {x[DATA_WIDTH-1], x} - {m[DATA_WIDTH-1], m};
`ifdef SOFTMAX_SAT_EN
    if (d < SAT_FLOOR) begin
      d = SAT_FLOOR;
    end
`endif
    return d;
  endfunction

  assign w_in_fire  = in_valid && in_ready_q && (state_q == S_LOAD);
  assign w_out_fire = out_valid_q && out_ready;
  assign w_vec_end  = in_last || (wr_cnt_q == LAST_IDX);
  assign w_rd_nxt   = rd_cnt_q + CW'(1);

  // Max including the element being accepted now; ties keep the old max.
  assign w_max_nxt = ((wr_cnt_q == '0) || (in_data > max_q)) ? in_data : max_q;
  // Element 0 is presented the cycle after the last input, so it may still be on the bus.
  assign w_first   = (wr_cnt_q == '0) ? in_data : mem_q[0];

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    last_idx_d  = last_idx_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_LOAD: begin
        if (w_in_fire) begin
          max_d    = w_max_nxt;
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (w_vec_end) begin
            last_idx_d  = wr_cnt_q;
            rd_cnt_d    = '0;
            state_d     = S_EMIT;
            out_valid_d = 1'b1;
            out_data_d  = sub_max(w_first, w_max_nxt);
            out_last_d  = (wr_cnt_q == '0);
          end
        end
      end
      S_EMIT: begin
        if (w_out_fire) begin
          if (out_last_q) begin
            state_d     = S_LOAD;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end else begin
            rd_cnt_d   = w_rd_nxt;
            out_data_d = sub_max(mem_q[w_rd_nxt], max_q);
            out_last_d = (w_rd_nxt == last_idx_q);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      last_idx_q  <= '0;
      max_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      last_idx_q  <= last_idx_d;
      max_q       <= max_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Buffer contents are only read after being written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      mem_q[wr_cnt_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign max_val   = max_q;

endmodule
`default_nettype wire

// File: tb/tb_softmax_max_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_max_sub
// Purpose  : Directed self-checking bench for softmax_max_sub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_max_sub;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic signed [8:0] out_data;
  logic              out_last;
  logic signed [7:0] max_val;

  int n_tests = 0;
  int n_fail  = 0;

  softmax_max_sub #(
    .DATA_WIDTH(8),
    .VEC_LEN   (8)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .max_val  (max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the final input edge.
  task automatic send(input int v[$], input bit use_last);
    for (int i = 0; i < v.size(); i++) begin
      int g = 0;
      while (!in_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = 8'(v[i]);
      in_last  = use_last && (i == v.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("latency_out_valid", out_valid, 1);
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0,...
  task automatic recv(input int e[$], input int mode);
    int k   = 0;
    int cyc = 0;
    while (k < e.size() && cyc < 100) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      check("out_valid", out_valid, 1);
      check("in_ready_emit", in_ready, 0);
      if (out_valid) begin
        check("out_data", out_data, e[k]);
        check("out_last", out_last, (k == e.size() - 1) ? 1 : 0);
        if (out_ready) k++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("recv_count", k, e.size());
    check("turnaround_in_ready", in_ready, 1);
    check("done_out_valid", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[$];
    int e[$];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_max_val", max_val, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Full vector
    v = '{12, 6, 1, -3, 5, -3, 0, 7};
    send(v, 1'b1);
    check("full_max", max_val, 12);
    e = '{0, -6, -11, -15, -7, -15, -12, -5};
    recv(e, 0);

    // Extremes
    v = '{-128, 127};
    send(v, 1'b1);
    check("ext_max", max_val, 127);
`ifdef SOFTMAX_SAT_EN
    e = '{-128, 0};
`else
    e = '{-255, 0};
`endif
    recv(e, 0);

    // Single element
    v = '{5};
    send(v, 1'b1);
    check("single_max", max_val, 5);
    e = '{0};
    recv(e, 0);

    // Ties
    v = '{3, 3, -1};
    send(v, 1'b1);
    check("tie_max", max_val, 3);
    e = '{0, 0, -4};
    recv(e, 0);

    // Forced end with backpressure
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    send(v, 1'b0);
    check("forced_max", max_val, 8);
    e = '{-7, -6, -5, -4, -3, -2, -1, 0};
    recv(e, 1);

    // Reset mid-emit
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    send(v, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_out_data", out_data, -4);
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_max_val", max_val, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerst_in_ready", in_ready, 1);
    v = '{2, 9};
    send(v, 1'b1);
    check("after_rst_max", max_val, 9);
    e = '{-7, 0};
    recv(e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
